// File: rtl/rob_pkg.sv
// Shared types for the reorder buffer: entry layout, pointer types and
// small pointer helpers used by the top module.
package rob_pkg;

    localparam int ROB_MSB   = 2;
    localparam int REG_MSB   = 4;
    localparam int WIDTH_MSB = 31;
    localparam int ROB_DEPTH = 2 ** (ROB_MSB + 1);

    // Pointer carries one extra wrap bit above the entry index
    typedef logic [ROB_MSB+1:0] rob_ptr_t;
    typedef logic [ROB_MSB:0]   rob_idx_t;

    typedef struct packed {
        logic                 valid;
        logic                 ready;
        logic                 mispredict;
        logic                 branch;
        logic                 regWrite;
        logic [REG_MSB:0]     dest;
        logic [WIDTH_MSB:0]   data;
        logic [WIDTH_MSB:0]   snap;
    } rob_entry_t;

    function automatic rob_idx_t ptr_idx(input rob_ptr_t p);
        return p[ROB_MSB:0];
    endfunction

    // Full when indices match but the pointers are a lap apart
    function automatic logic ptr_full(input rob_ptr_t h, input rob_ptr_t t);
        return (h[ROB_MSB:0] == t[ROB_MSB:0]) && (h[ROB_MSB+1] != t[ROB_MSB+1]);
    endfunction

endpackage

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates at rename, collects CDB writebacks and
// retires strictly in program order. A mispredicted branch at the head
// requests a pipeline flush and supplies its rename-time busy snapshot.
module reorder_buffer
    import rob_pkg::*;
#(
    parameter int ROB   = ROB_MSB,
    parameter int REG   = REG_MSB,
    parameter int WIDTH = WIDTH_MSB
) (
    input  logic             clk,
    input  logic             globalReset,
    input  logic             alloc,
    input  logic [REG:0]     allocDest,
    input  logic             allocRegWrite,
    input  logic             allocBranch,
    input  logic [WIDTH:0]   allocSnap,
    output logic [ROB:0]     destROB,
    output logic             full,
    output logic             empty,
    input  logic             cdbValid,
    input  logic [ROB:0]     cdbROB,
    input  logic [WIDTH:0]   cdbData,
    input  logic             cdbMispredict,
    output logic             validCommit,
    output logic [ROB:0]     commitROB,
    output logic [REG:0]     regCommit,
    output logic             commitRegWrite,
    output logic [WIDTH:0]   commitData,
    output logic             reset,
    output logic [WIDTH:0]   statusRestore
);

    rob_entry_t entries_q [ROB_DEPTH];
    rob_entry_t entries_d [ROB_DEPTH];
    rob_ptr_t   head_q, head_d;
    rob_ptr_t   tail_q, tail_d;
    rob_entry_t head_entry_s;
    logic       flush_s;

    // Status and commit-side outputs decoded from registered state only
    always_comb begin
        head_entry_s   = entries_q[ptr_idx(head_q)];
        empty          = (head_q == tail_q);
        full           = ptr_full(head_q, tail_q);
        destROB        = ptr_idx(tail_q);
        validCommit    = head_entry_s.valid & head_entry_s.ready;
        flush_s        = validCommit & head_entry_s.mispredict;
        reset          = flush_s;
        commitROB      = ptr_idx(head_q);
        regCommit      = head_entry_s.dest;
        commitRegWrite = head_entry_s.regWrite;
        commitData     = head_entry_s.data;
        statusRestore  = head_entry_s.snap;
    end

    // Next-state for entries and pointers: reset, flush, or writeback/alloc/retire
    always_comb begin
        entries_d = entries_q;
        head_d    = head_q;
        tail_d    = tail_q;
        if (globalReset) begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                entries_d[i] = '0;
            end
            head_d = '0;
            tail_d = '0;
        end else if (flush_s) begin
            // Everything younger than the branch is discarded; payloads stay
            for (int i = 0; i < ROB_DEPTH; i++) begin
                entries_d[i].valid = 1'b0;
            end
            head_d = '0;
            tail_d = '0;
        end else begin
            if (cdbValid && entries_q[cdbROB].valid) begin
                entries_d[cdbROB].ready      = 1'b1;
                entries_d[cdbROB].data       = cdbData;
                entries_d[cdbROB].mispredict = cdbMispredict & entries_q[cdbROB].branch;
            end else begin
                entries_d[cdbROB] = entries_d[cdbROB];
            end
            // Allocation cannot collide with the retiring head: that would need empty or full
            if (alloc && !full) begin
                entries_d[ptr_idx(tail_q)].valid      = 1'b1;
                entries_d[ptr_idx(tail_q)].ready      = 1'b0;
                entries_d[ptr_idx(tail_q)].mispredict = 1'b0;
                entries_d[ptr_idx(tail_q)].branch     = allocBranch;
                entries_d[ptr_idx(tail_q)].regWrite   = allocRegWrite;
                entries_d[ptr_idx(tail_q)].dest       = allocDest;
                if (allocBranch) begin
                    entries_d[ptr_idx(tail_q)].snap = allocSnap;
                end else begin
                    entries_d[ptr_idx(tail_q)].snap = entries_q[ptr_idx(tail_q)].snap;
                end
                tail_d = tail_q + 4'd1;
            end else begin
                tail_d = tail_q;
            end
            if (validCommit) begin
                entries_d[ptr_idx(head_q)].valid = 1'b0;
                head_d = head_q + 4'd1;
            end else begin
                head_d = head_q;
            end
        end
    end

    // State registers; reset behaviour is folded into the next-state logic
    always_ff @(posedge clk) begin
        entries_q <= entries_d;
        head_q    <= head_d;
        tail_q    <= tail_d;
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer.
module tb_reorder_buffer;

    logic        clk = 1'b0;
    logic        globalReset, alloc, allocRegWrite, allocBranch;
    logic [4:0]  allocDest;
    logic [31:0] allocSnap;
    logic [2:0]  destROB;
    logic        full, empty;
    logic        cdbValid, cdbMispredict;
    logic [2:0]  cdbROB;
    logic [31:0] cdbData;
    logic        validCommit, commitRegWrite, reset;
    logic [2:0]  commitROB;
    logic [4:0]  regCommit;
    logic [31:0] commitData, statusRestore;

    int checks   = 0;
    int failures = 0;

    reorder_buffer dut (
        .clk(clk), .globalReset(globalReset), .alloc(alloc), .allocDest(allocDest),
        .allocRegWrite(allocRegWrite), .allocBranch(allocBranch), .allocSnap(allocSnap),
        .destROB(destROB), .full(full), .empty(empty), .cdbValid(cdbValid),
        .cdbROB(cdbROB), .cdbData(cdbData), .cdbMispredict(cdbMispredict),
        .validCommit(validCommit), .commitROB(commitROB), .regCommit(regCommit),
        .commitRegWrite(commitRegWrite), .commitData(commitData), .reset(reset),
        .statusRestore(statusRestore)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_empty"}, 32'(empty), 32'd1);
        chk({tag, "_full"}, 32'(full), 32'd0);
        chk({tag, "_destROB"}, 32'(destROB), 32'd0);
        chk({tag, "_validCommit"}, 32'(validCommit), 32'd0);
        chk({tag, "_reset"}, 32'(reset), 32'd0);
        chk({tag, "_commitROB"}, 32'(commitROB), 32'd0);
        chk({tag, "_regCommit"}, 32'(regCommit), 32'd0);
        chk({tag, "_commitRegWrite"}, 32'(commitRegWrite), 32'd0);
        chk({tag, "_commitData"}, commitData, 32'd0);
        chk({tag, "_statusRestore"}, statusRestore, 32'd0);
    endtask

    task automatic do_greset();
        globalReset = 1'b1;
        tick();
        globalReset = 1'b0;
    endtask

    initial begin
        globalReset = 1'b1; alloc = 1'b0; allocDest = 5'd0; allocRegWrite = 1'b0;
        allocBranch = 1'b0; allocSnap = 32'd0; cdbValid = 1'b0; cdbROB = 3'd0;
        cdbData = 32'd0; cdbMispredict = 1'b0;
        tick();
        tick();
        globalReset = 1'b0;
        chk_reset_state("rst");

        // Retire in order
        alloc = 1'b1; allocRegWrite = 1'b1; allocDest = 5'd5;
        chk("ord_dest0", 32'(destROB), 32'd0);
        tick();
        chk("ord_dest1", 32'(destROB), 32'd1);
        allocDest = 5'd6;
        tick();
        chk("ord_dest2", 32'(destROB), 32'd2);
        allocDest = 5'd7;
        tick();
        alloc = 1'b0;
        chk("ord_notempty", 32'(empty), 32'd0);
        cdbValid = 1'b1; cdbROB = 3'd2; cdbData = 32'h22;
        tick();
        chk("ord_wait_head", 32'(validCommit), 32'd0);
        cdbROB = 3'd0; cdbData = 32'h10;
        tick();
        chk("ord_vc0", 32'(validCommit), 32'd1);
        chk("ord_rob0", 32'(commitROB), 32'd0);
        chk("ord_reg0", 32'(regCommit), 32'd5);
        chk("ord_data0", commitData, 32'h10);
        chk("ord_rw0", 32'(commitRegWrite), 32'd1);
        cdbROB = 3'd1; cdbData = 32'h11;
        tick();
        cdbValid = 1'b0;
        chk("ord_vc1", 32'(validCommit), 32'd1);
        chk("ord_rob1", 32'(commitROB), 32'd1);
        chk("ord_reg1", 32'(regCommit), 32'd6);
        chk("ord_data1", commitData, 32'h11);
        tick();
        chk("ord_vc2", 32'(validCommit), 32'd1);
        chk("ord_rob2", 32'(commitROB), 32'd2);
        chk("ord_reg2", 32'(regCommit), 32'd7);
        chk("ord_data2", commitData, 32'h22);
        tick();
        chk("ord_empty", 32'(empty), 32'd1);
        chk("ord_vc_done", 32'(validCommit), 32'd0);

        // Full and wrap
        do_greset();
        alloc = 1'b1;
        for (int i = 0; i < 8; i++) begin
            allocDest = 5'(i + 1);
            tick();
        end
        chk("full_set", 32'(full), 32'd1);
        chk("full_tail_idx", 32'(destROB), 32'd0);
        allocDest = 5'd9;
        tick();
        alloc = 1'b0;
        chk("full_still", 32'(full), 32'd1);
        chk("full_drop_head_reg", 32'(regCommit), 32'd1);
        cdbValid = 1'b1; cdbROB = 3'd0; cdbData = 32'hAB;
        tick();
        cdbValid = 1'b0;
        chk("full_retire_vc", 32'(validCommit), 32'd1);
        alloc = 1'b1; allocDest = 5'd20;
        tick();
        chk("full_refused_alloc", 32'(full), 32'd0);
        chk("full_tail_held", 32'(destROB), 32'd0);
        chk("full_head_adv", 32'(commitROB), 32'd1);
        tick();
        alloc = 1'b0;
        chk("wrap_full_again", 32'(full), 32'd1);
        chk("wrap_dest1", 32'(destROB), 32'd1);

        // Simultaneous allocate and retire with four occupied
        do_greset();
        alloc = 1'b1;
        for (int i = 0; i < 4; i++) begin
            allocDest = 5'(i + 1);
            tick();
        end
        alloc = 1'b0;
        cdbValid = 1'b1; cdbROB = 3'd0; cdbData = 32'h5;
        tick();
        cdbValid = 1'b0;
        chk("sim_vc", 32'(validCommit), 32'd1);
        alloc = 1'b1; allocDest = 5'd5;
        tick();
        alloc = 1'b0;
        chk("sim_tail", 32'(destROB), 32'd5);
        chk("sim_head", 32'(commitROB), 32'd1);
        chk("sim_notfull", 32'(full), 32'd0);
        chk("sim_notempty", 32'(empty), 32'd0);

        // Stale writeback to an unallocated entry
        do_greset();
        cdbValid = 1'b1; cdbROB = 3'd0; cdbData = 32'hDEAD;
        tick();
        cdbValid = 1'b0;
        chk("stale_vc", 32'(validCommit), 32'd0);
        chk("stale_data", commitData, 32'd0);
        chk("stale_empty", 32'(empty), 32'd1);

        // Mispredict flush
        do_greset();
        alloc = 1'b1; allocRegWrite = 1'b1; allocDest = 5'd3; allocBranch = 1'b0;
        tick();
        allocDest = 5'd4; allocBranch = 1'b1; allocSnap = 32'h0000_00A0;
        tick();
        allocDest = 5'd8; allocBranch = 1'b0; allocSnap = 32'h0;
        tick();
        allocDest = 5'd9;
        tick();
        alloc = 1'b0;
        cdbValid = 1'b1; cdbROB = 3'd0; cdbData = 32'h1;
        tick();
        chk("mp_vc0", 32'(validCommit), 32'd1);
        chk("mp_noreset0", 32'(reset), 32'd0);
        chk("mp_rob0", 32'(commitROB), 32'd0);
        cdbROB = 3'd1; cdbMispredict = 1'b1; cdbData = 32'h2;
        tick();
        cdbValid = 1'b0; cdbMispredict = 1'b0;
        chk("mp_vc1", 32'(validCommit), 32'd1);
        chk("mp_reset", 32'(reset), 32'd1);
        chk("mp_rob1", 32'(commitROB), 32'd1);
        chk("mp_restore", statusRestore, 32'h0000_00A0);
        alloc = 1'b1; allocDest = 5'd11;
        tick();
        alloc = 1'b0;
        chk("mp_empty", 32'(empty), 32'd1);
        chk("mp_destROB", 32'(destROB), 32'd0);
        chk("mp_vc_after", 32'(validCommit), 32'd0);
        chk("mp_reset_after", 32'(reset), 32'd0);

        // globalReset in the same cycle as a flush retire
        do_greset();
        alloc = 1'b1; allocDest = 5'd9; allocBranch = 1'b1; allocSnap = 32'h55;
        tick();
        alloc = 1'b0; allocBranch = 1'b0;
        cdbValid = 1'b1; cdbROB = 3'd0; cdbMispredict = 1'b1; cdbData = 32'h77;
        tick();
        chk("gr_flush_pending", 32'(reset), 32'd1);
        chk("gr_restore_pending", statusRestore, 32'h55);
        globalReset = 1'b1; alloc = 1'b1;
        tick();
        globalReset = 1'b0; alloc = 1'b0; cdbValid = 1'b0; cdbMispredict = 1'b0;
        chk_reset_state("gr");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
